// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, size defaults
// and the request fault classifier.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEPTH_DEFAULT = 256;
  localparam int IDX_W_DEFAULT = 8;
  localparam int WAIT_DEFAULT  = 2;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_MISALIGN = 2'd1,
    FAULT_RANGE    = 2'd2,
    FAULT_CONFLICT = 2'd3
  } fault_t;

  // Anything above the word-index field must be zero, otherwise the access would alias.
  function automatic fault_t check_fault(input logic rd, input logic wr,
                                         input logic [63:0] addr, input int idx_w);
    fault_t f;
    f = FAULT_NONE;
    if (addr[2:0] != 3'd0) f = FAULT_MISALIGN;
    else if ((addr >> (idx_w + 3)) != 64'd0) f = FAULT_RANGE;
    else if (rd && wr) f = FAULT_CONFLICT;
    return f;
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous write, combinational read on the same index.
module dmem_array #(
  parameter int DEPTH = 256,
  parameter int IDX_W = 8
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [63:0]      wdata,
  output logic [63:0]      rdata
);

  logic [63:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: latches one load/store, waits WAIT_CYCLES, then commits
// and pulses oReady (with oAddrError on a faulting request).
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH       = DEPTH_DEFAULT,
  parameter int IDX_W       = IDX_W_DEFAULT,
  parameter int WAIT_CYCLES = WAIT_DEFAULT
) (
  input  logic        iCLK,
  input  logic        iReset,
  input  logic        iMemRead,
  input  logic        iMemWrite,
  input  logic [63:0] iAddress,
  input  logic [63:0] iWriteData,
  output logic [63:0] oMemData,
  output logic        oReady,
  output logic        oBusy,
  output logic        oAddrError
);

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t      state, next_state;
  logic [3:0]  count;
  logic        rd_q, wr_q, fault_q;
  logic [63:0] addr_q, wdata_q;

  logic             req, enter_done, cur_fault, array_we;
  logic             cur_rd, cur_wr;
  logic [63:0]      cur_addr, cur_wdata, rdata;
  logic [IDX_W-1:0] idx;

  assign req = iMemRead | iMemWrite;

  // With zero wait states DONE is entered on the sampling edge, so the live inputs
  // must stand in for the not-yet-latched copies.
  always_comb begin
    cur_rd    = rd_q;
    cur_wr    = wr_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    if (state == IDLE) begin
      cur_rd    = iMemRead;
      cur_wr    = iMemWrite;
      cur_addr  = iAddress;
      cur_wdata = iWriteData;
    end
  end

  assign cur_fault = (check_fault(cur_rd, cur_wr, cur_addr, IDX_W) != FAULT_NONE);
  assign idx       = cur_addr[IDX_W+2:3];
  assign array_we  = enter_done & cur_wr & ~cur_fault;

  always_comb begin
    next_state = state;
    enter_done = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES == 0) begin
            next_state = DONE;
            enter_done = 1'b1;
          end else begin
            next_state = WAIT;
          end
        end
      end
      WAIT: begin
        if (count == 4'd1) begin
          next_state = DONE;
          enter_done = 1'b1;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge iCLK or posedge iReset) begin
    if (iReset) begin
      state    <= IDLE;
      count    <= 4'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= 64'd0;
      wdata_q  <= 64'd0;
      fault_q  <= 1'b0;
      oMemData <= 64'd0;
    end else begin
      state <= next_state;
      if (state == IDLE && req) begin
        rd_q    <= iMemRead;
        wr_q    <= iMemWrite;
        addr_q  <= iAddress;
        wdata_q <= iWriteData;
        count   <= WAIT_INIT;
      end else if (state == WAIT) begin
        count <= count - 4'd1;
      end
      if (enter_done) begin
        fault_q <= cur_fault;
        if (cur_rd && !cur_fault) oMemData <= rdata;
      end
    end
  end

  assign oReady     = (state == DONE);
  assign oBusy      = (state != IDLE);
  assign oAddrError = oReady & fault_q;

  dmem_array #(
    .DEPTH(DEPTH),
    .IDX_W(IDX_W)
  ) u_array (
    .clk  (iCLK),
    .we   (array_we),
    .idx  (idx),
    .wdata(cur_wdata),
    .rdata(rdata)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
// Self-checking bench: randomized accesses against a transaction-level timeline model,
// plus directed scenarios and a zero-wait-state instance.
module tb_data_mem_responder;

  localparam int W     = 2;
  localparam int DEPTH = 256;
  localparam int IDX_W = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rd = 1'b0, wr = 1'b0;
  logic [63:0] addr = 64'd0, wdata = 64'd0;
  logic [63:0] mem_data;
  logic ready, busy, addr_err;

  logic rd0 = 1'b0, wr0 = 1'b0;
  logic [63:0] addr0 = 64'd0, wdata0 = 64'd0;
  logic [63:0] mem_data0;
  logic ready0, busy0, err0;

  int compared = 0;
  int mismatched = 0;
  logic check_en = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYCLES(W)) dut (
    .iCLK(clk), .iReset(rst), .iMemRead(rd), .iMemWrite(wr),
    .iAddress(addr), .iWriteData(wdata),
    .oMemData(mem_data), .oReady(ready), .oBusy(busy), .oAddrError(addr_err)
  );

  data_mem_responder #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WAIT_CYCLES(0)) dut0 (
    .iCLK(clk), .iReset(rst), .iMemRead(rd0), .iMemWrite(wr0),
    .iAddress(addr0), .iWriteData(wdata0),
    .oMemData(mem_data0), .oReady(ready0), .oBusy(busy0), .oAddrError(err0)
  );

  function automatic void checkOutput(input string name, input logic [63:0] act,
                                      input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  // Timeline model: a request sampled on edge s occupies intervals s..s+W and
  // completes (commits, pulses ready) in interval s+W.
  logic [63:0] mem_model [DEPTH];
  int          cyc = 0;
  int          done_cyc = -1;
  logic        m_rd, m_wr, m_fault = 1'b0;
  logic [63:0] m_addr, m_wdata;
  logic [63:0] exp_data = 64'd0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      done_cyc = -1;
      exp_data = 64'd0;
      m_fault  = 1'b0;
    end else begin
      cyc++;
      if ((cyc - 1) > done_cyc && (rd || wr)) begin
        m_rd     = rd;
        m_wr     = wr;
        m_addr   = addr;
        m_wdata  = wdata;
        done_cyc = cyc + W;
      end
      if (cyc == done_cyc) begin
        m_fault = (m_addr % 8 != 0) || (m_addr >= 64'(DEPTH * 8)) || (m_rd && m_wr);
        if (!m_fault && m_wr) mem_model[m_addr / 8] = m_wdata;
        if (!m_fault && m_rd) exp_data = mem_model[m_addr / 8];
      end
    end
  end

  logic exp_busy, exp_ready;
  always @(negedge clk) begin
    if (check_en) begin
      exp_busy  = !rst && (cyc <= done_cyc);
      exp_ready = !rst && (cyc == done_cyc);
      checkOutput("busy", busy, exp_busy);
      checkOutput("ready", ready, exp_ready);
      checkOutput("addr_err", addr_err, exp_ready && m_fault);
      checkOutput("mem_data", mem_data, exp_data);
    end
  end

  // One complete requester handshake; address/data are scrambled while waiting
  // because the responder must be working from its latched copies.
  task automatic applyStimulus(input logic r, input logic w, input logic [63:0] a,
                               input logic [63:0] d, output logic err, output int lat);
    logic got;
    @(posedge clk);
    #2;
    rd = r; wr = w; addr = a; wdata = d;
    lat = 0; err = 1'b0; got = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      lat++;
      if (ready) begin
        err = addr_err;
        got = 1'b1;
        break;
      end
      addr  = {$urandom, $urandom};
      wdata = {$urandom, $urandom};
    end
    if (!got) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL ready_timeout: got no ready expected ready within 40 cycles");
    end
    @(posedge clk);
    #2;
    rd = 1'b0; wr = 1'b0;
  endtask

  logic        err;
  int          lat;
  logic [63:0] a;
  logic        r, w;
  int          kind;

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    check_en = 1'b1;
    @(negedge clk);
    checkOutput("reset_data", mem_data, 64'd0);
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_busy", busy, 1'b0);

    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1'b0, 1'b1, 64'(i) << 3, {$urandom, $urandom}, err, lat);

    applyStimulus(1'b0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, err, lat);
    checkOutput("stur_latency", 64'(lat), 64'd3);
    checkOutput("stur_err", err, 1'b0);
    applyStimulus(1'b1, 1'b0, 64'h10, 64'd0, err, lat);
    checkOutput("ldur_data", mem_data, 64'hDEADBEEF_CAFEF00D);

    applyStimulus(1'b1, 1'b0, 64'h13, 64'd0, err, lat);
    checkOutput("misalign_err", err, 1'b1);
    checkOutput("misalign_hold", mem_data, 64'hDEADBEEF_CAFEF00D);

    applyStimulus(1'b0, 1'b1, 64'h0, 64'h1111_2222_3333_4444, err, lat);
    applyStimulus(1'b0, 1'b1, 64'h800, 64'hBAD0_BAD0_BAD0_BAD0, err, lat);
    checkOutput("range_err", err, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'h0, 64'd0, err, lat);
    checkOutput("range_no_alias", mem_data, 64'h1111_2222_3333_4444);

    applyStimulus(1'b0, 1'b1, 64'h8, 64'hAAAA_5555_AAAA_5555, err, lat);
    applyStimulus(1'b1, 1'b1, 64'h8, 64'h5, err, lat);
    checkOutput("conflict_err", err, 1'b1);
    applyStimulus(1'b1, 1'b0, 64'h8, 64'd0, err, lat);
    checkOutput("conflict_no_write", mem_data, 64'hAAAA_5555_AAAA_5555);

    applyStimulus(1'b0, 1'b1, 64'h20, 64'h5555_6666_7777_8888, err, lat);
    @(posedge clk);
    #2;
    wr = 1'b1; addr = 64'h20; wdata = 64'h1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    checkOutput("abort_ready", ready, 1'b0);
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_data", mem_data, 64'd0);
    #1;
    wr = 1'b0;
    rst = 1'b0;
    applyStimulus(1'b1, 1'b0, 64'h20, 64'd0, err, lat);
    checkOutput("abort_no_write", mem_data, 64'h5555_6666_7777_8888);

    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      a = 64'($urandom_range(0, DEPTH - 1)) << 3;
      r = 1'($urandom_range(0, 1));
      w = !r;
      case (kind)
        6: a[2:0] = 3'($urandom_range(1, 7));
        7: a[$urandom_range(IDX_W + 3, 63)] = 1'b1;
        8: begin r = 1'b1; w = 1'b1; end
        default: ;
      endcase
      applyStimulus(r, w, a, {$urandom, $urandom}, err, lat);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Zero wait states with the request held: completion every other cycle.
    @(posedge clk);
    #2;
    wr0 = 1'b1; addr0 = 64'h18; wdata0 = 64'h77;
    @(posedge clk);
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      checkOutput("w0_ready", ready0, (k % 2) == 0);
      checkOutput("w0_busy", busy0, (k % 2) == 0);
      checkOutput("w0_err", err0, (k >= 8) && ((k % 2) == 0));
      if (k == 7) addr0 = 64'h1C;
    end
    wr0 = 1'b0;

    repeat (3) @(posedge clk);
    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish expected finish before 500000");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
